// File: rtl/ex_stage_muldiv.sv
// Execute stage: single-cycle ALU plus a shared 32-step sequential
// multiply/divide unit, feeding the EX/MEM pipeline register.
module ex_stage_muldiv #(
    parameter int XLEN     = 32,
    parameter int MD_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_e,
    input  logic            md_en_e,
    input  logic [2:0]      alu_ctrl_e,
    input  logic            alu_src_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_e,
    input  logic [4:0]      a3_e,
    input  logic            reg_write_e,
    input  logic [1:0]      mem_ctrl_e,
    input  logic            flush_e,
    output logic            stall_e,
    output logic [XLEN-1:0] alu_out_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [4:0]      a3_m,
    output logic            reg_write_m,
    output logic [1:0]      mem_ctrl_m,
    output logic [2:0]      funct3_m,
    output logic            valid_m
);

    localparam int CW = $clog2(MD_ITERS);
    localparam logic [CW-1:0] LAST = CW'(MD_ITERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;       // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opb_mag;   // multiplicand or divisor magnitude
    logic [2:0]        op_q;
    logic              neg_res, neg_rem, div0;
    logic [4:0]        a3_q;
    logic              rw_q;
    logic [1:0]        mc_q;

    function automatic logic [XLEN-1:0] alu_op(input logic [2:0] ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (ctrl)
            3'b000: r = a + b;
            3'b001: r = a - b;
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: r = {{(XLEN-1){1'b0}}, (sa < sb)};
            3'b110: r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        return r;
    endfunction

    // Signed fix-up of the unsigned magnitude result and op selection.
    function automatic logic [XLEN-1:0] md_result(input logic [2:0] op,
                                                  input logic [2*XLEN-1:0] r,
                                                  input logic neg, input logic negr,
                                                  input logic dz);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? -r : r;
        quo  = dz ? '1 : (neg ? -r[XLEN-1:0] : r[XLEN-1:0]);
        rem  = negr ? -r[2*XLEN-1:XLEN] : r[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 return prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: return prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         return quo;
            default:                return rem;
        endcase
    endfunction

    logic            md_start;
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic [XLEN:0]   div_diff;

    assign md_start = (state == IDLE) && valid_e && md_en_e && !flush_e;
    assign a_sgn    = rd1_e[XLEN-1] && !(funct3_e == 3'b011 || funct3_e == 3'b101 ||
                                         funct3_e == 3'b111);
    assign b_sgn    = rd2_e[XLEN-1] && (funct3_e == 3'b000 || funct3_e == 3'b001 ||
                                        funct3_e == 3'b100 || funct3_e == 3'b110);
    assign a_mag    = a_sgn ? -rd1_e : rd1_e;
    assign b_mag    = b_sgn ? -rd2_e : rd2_e;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_mag} : '0);
    assign div_sh   = acc[2*XLEN-1:XLEN-1];
    assign div_ge   = div_sh >= {1'b0, opb_mag};
    assign div_diff = div_sh - {1'b0, opb_mag};

    assign stall_e  = !rst && !flush_e &&
                      ((state == IDLE && valid_e && md_en_e) || state == BUSY);

    // Multiply/divide datapath: latch operands on start, one step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (md_start) begin
            acc     <= {{XLEN{1'b0}}, a_mag};
            opb_mag <= b_mag;
            op_q    <= funct3_e;
            div0    <= funct3_e[2] && (rd2_e == '0);
            neg_res <= a_sgn ^ b_sgn;
            neg_rem <= a_sgn;
            a3_q    <= a3_e;
            rw_q    <= reg_write_e;
            mc_q    <= mem_ctrl_e;
        end else if (state == BUSY) begin
            if (op_q[2])
                acc <= {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
            else
                acc <= {mul_sum, acc[XLEN-1:1]};
        end
    end

    // FSM state and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == BUSY && !flush_e) ? cnt + 1'b1 : '0;
        end
    end

    logic [XLEN-1:0] alu_nxt, wd_nxt;
    logic [4:0]      a3_nxt;
    logic            rw_nxt, vld_nxt;
    logic [1:0]      mc_nxt;
    logic [2:0]      f3_nxt;

    // Next state and EX/MEM next values; a bubble unless something retires.
    always_comb begin
        state_nxt = state;
        alu_nxt   = '0;
        wd_nxt    = '0;
        a3_nxt    = '0;
        rw_nxt    = 1'b0;
        vld_nxt   = 1'b0;
        mc_nxt    = '0;
        f3_nxt    = '0;
        if (flush_e) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_e && md_en_e) begin
                        state_nxt = BUSY;
                    end else if (valid_e) begin
                        alu_nxt = alu_op(alu_ctrl_e, rd1_e, alu_src_e ? imm_e : rd2_e);
                        wd_nxt  = rd2_e;
                        a3_nxt  = a3_e;
                        rw_nxt  = reg_write_e;
                        vld_nxt = 1'b1;
                        mc_nxt  = mem_ctrl_e;
                        f3_nxt  = funct3_e;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) state_nxt = DONE;
                end
                default: begin
                    alu_nxt   = md_result(op_q, acc, neg_res, neg_rem, div0);
                    wd_nxt    = rd2_e;
                    a3_nxt    = a3_q;
                    rw_nxt    = rw_q;
                    vld_nxt   = 1'b1;
                    mc_nxt    = mc_q;
                    f3_nxt    = op_q;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_m    <= '0;
            write_data_m <= '0;
            a3_m         <= '0;
            reg_write_m  <= 1'b0;
            mem_ctrl_m   <= '0;
            funct3_m     <= '0;
            valid_m      <= 1'b0;
        end else begin
            alu_out_m    <= alu_nxt;
            write_data_m <= wd_nxt;
            a3_m         <= a3_nxt;
            reg_write_m  <= rw_nxt;
            mem_ctrl_m   <= mc_nxt;
            funct3_m     <= f3_nxt;
            valid_m      <= vld_nxt;
        end
    end

endmodule
